// File: rtl/lc3_ctrl_pkg.sv
// LC-3 control unit shared types: state numbering, opcodes,
// mux/ALU encodings and the packed control word.
package lc3_ctrl_pkg;

    // LC-3 microstate numbers; 32..35 need a sixth bit.
    typedef enum logic [5:0] {
        S_BR       = 6'd0,
        S_ADD      = 6'd1,
        S_LD       = 6'd2,
        S_ST       = 6'd3,
        S_JSR      = 6'd4,
        S_AND      = 6'd5,
        S_LDR      = 6'd6,
        S_STR      = 6'd7,
        S_NOT      = 6'd9,
        S_LDI      = 6'd10,
        S_STI      = 6'd11,
        S_JMP      = 6'd12,
        S_LEA      = 6'd14,
        S_TRAP     = 6'd15,
        S_WR       = 6'd16,
        S_FETCH    = 6'd18,
        S_JSRR     = 6'd20,
        S_JSR_OFF  = 6'd21,
        S_BR_TAKE  = 6'd22,
        S_ST_MDR   = 6'd23,
        S_LDI_RD   = 6'd24,
        S_RD       = 6'd25,
        S_LDI_MAR  = 6'd26,
        S_LD_DR    = 6'd27,
        S_TRAP_RD  = 6'd28,
        S_STI_RD   = 6'd29,
        S_TRAP_PC  = 6'd30,
        S_STI_MAR  = 6'd31,
        S_DECODE   = 6'd32,
        S_FETCH_RD = 6'd33,
        S_LD_IR    = 6'd35
    } state_t;

    localparam logic [3:0] OP_RTI = 4'd8;
    localparam logic [3:0] OP_RSV = 4'd13;

    localparam logic       MARMUX_ZEXT  = 1'b0;
    localparam logic       MARMUX_ADDER = 1'b1;
    localparam logic       ADDR1_PC     = 1'b0;
    localparam logic       ADDR1_SR1    = 1'b1;
    localparam logic [1:0] ADDR2_ZERO   = 2'd0;
    localparam logic [1:0] ADDR2_OFF6   = 2'd1;
    localparam logic [1:0] ADDR2_OFF9   = 2'd2;
    localparam logic [1:0] ADDR2_OFF11  = 2'd3;
    localparam logic [1:0] PCMUX_INC    = 2'd0;
    localparam logic [1:0] PCMUX_BUS    = 2'd1;
    localparam logic [1:0] PCMUX_ADDER  = 2'd2;
    localparam logic [1:0] DRMUX_IR     = 2'd0;
    localparam logic [1:0] DRMUX_R7     = 2'd1;
    localparam logic [1:0] SR1MUX_IR119 = 2'd0;
    localparam logic [1:0] SR1MUX_IR86  = 2'd1;
    localparam logic [1:0] ALU_ADD      = 2'd0;
    localparam logic [1:0] ALU_AND      = 2'd1;
    localparam logic [1:0] ALU_NOT      = 2'd2;
    localparam logic [1:0] ALU_PASS     = 2'd3;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_ben;
        logic       gate_marmux;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_pc;
        logic       marmux;
        logic       addr1;
        logic [1:0] addr2;
        logic [1:0] pcmux;
        logic [1:0] drmux;
        logic [1:0] sr1mux;
        logic [1:0] aluk;
        logic       cs;
        logic       we;
    } ctl_t;

    // States that wait on READY before advancing.
    function automatic logic mem_state(state_t s);
        return s inside {S_FETCH_RD, S_LDI_RD, S_RD,
                         S_TRAP_RD, S_STI_RD, S_WR};
    endfunction

endpackage

// File: rtl/lc3_control_unit_if.sv
// Control unit <-> datapath bundle. master: control unit
// (drives strobes/selects/CC); slave: datapath (BUS, IR, READY).
interface lc3_ctrl_if;
    logic [15:0] BUS;
    logic [15:0] IR;
    logic        READY;
    logic        LD_MAR, LD_MDR, LD_IR, LD_PC;
    logic        LD_REG, LD_CC, LD_BEN;
    logic        GateMARMUX, GateMDR, GateALU, GatePC;
    logic        MARMUXsel, ADDR1MUXsel;
    logic [1:0]  ADDR2MUXsel, PCMUXsel, DRMUXsel, SR1MUXsel;
    logic [1:0]  ALUK;
    logic        CS, WE;
    logic        N, Z, P, BEN;

    modport master (
        input  BUS, IR, READY,
        output LD_MAR, LD_MDR, LD_IR, LD_PC,
        output LD_REG, LD_CC, LD_BEN,
        output GateMARMUX, GateMDR, GateALU, GatePC,
        output MARMUXsel, ADDR1MUXsel,
        output ADDR2MUXsel, PCMUXsel, DRMUXsel, SR1MUXsel,
        output ALUK, CS, WE, N, Z, P, BEN
    );

    modport slave (
        output BUS, IR, READY,
        input  LD_MAR, LD_MDR, LD_IR, LD_PC,
        input  LD_REG, LD_CC, LD_BEN,
        input  GateMARMUX, GateMDR, GateALU, GatePC,
        input  MARMUXsel, ADDR1MUXsel,
        input  ADDR2MUXsel, PCMUXsel, DRMUXsel, SR1MUXsel,
        input  ALUK, CS, WE, N, Z, P, BEN
    );
endinterface

// File: rtl/lc3_cc_ben.sv
// NZP condition codes and branch-enable latch.
// Ports: clk, reset (sync, active-low), bus, ir_nzp, ld_cc, ld_ben -> n, z, p, ben.
module lc3_cc_ben (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus,
    input  logic [2:0]  ir_nzp,
    input  logic        ld_cc,
    input  logic        ld_ben,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic        ben
);
    logic bus_zero;
    assign bus_zero = (bus == 16'h0000);

    always_ff @(posedge clk) begin
        if (!reset) begin
            {n, z, p} <= 3'b010;
            ben       <= 1'b0;
        end else begin
            if (ld_cc) begin
                n <= bus[15];
                z <= bus_zero;
                p <= !bus[15] && !bus_zero;
            end
            if (ld_ben)
                ben <= |(ir_nzp & {n, z, p});
        end
    end
endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 microsequencer: state register, next-state logic and Moore
// output decode. Ports: CLK, RESET (sync, active-low), dp (master).
module lc3_control_unit
    import lc3_ctrl_pkg::*;
(
    input  logic      CLK,
    input  logic      RESET,
    lc3_ctrl_if.master dp
);
    state_t     state, nxt;
    ctl_t       raw, ctl;
    logic [3:0] op;
    logic       n, z, p, ben;
    logic       unused_ir;

    assign op        = dp.IR[15:12];
    assign unused_ir = ^dp.IR[8:0];

    always_comb begin
        nxt = S_FETCH;
        if (mem_state(state) && !dp.READY) begin
            nxt = state;
        end else begin
            unique case (state)
                S_FETCH:    nxt = S_FETCH_RD;
                S_FETCH_RD: nxt = S_LD_IR;
                S_LD_IR:    nxt = S_DECODE;
                S_DECODE:   nxt = (op == OP_RTI || op == OP_RSV)
                                  ? S_FETCH : state_t'({2'b00, op});
                S_BR:       nxt = ben ? S_BR_TAKE : S_FETCH;
                S_JSR:      nxt = dp.IR[11] ? S_JSR_OFF : S_JSRR;
                S_LD, S_LDR, S_LDI_MAR:
                            nxt = S_RD;
                S_RD:       nxt = S_LD_DR;
                S_LDI:      nxt = S_LDI_RD;
                S_LDI_RD:   nxt = S_LDI_MAR;
                S_ST, S_STR, S_STI_MAR:
                            nxt = S_ST_MDR;
                S_STI:      nxt = S_STI_RD;
                S_STI_RD:   nxt = S_STI_MAR;
                S_ST_MDR:   nxt = S_WR;
                S_TRAP:     nxt = S_TRAP_RD;
                S_TRAP_RD:  nxt = S_TRAP_PC;
                default:    nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET)
            state <= S_FETCH;
        else
            state <= nxt;
    end

    always_comb begin
        raw = '0;
        unique case (state)
            S_FETCH: begin
                raw.gate_pc = 1'b1;
                raw.ld_mar  = 1'b1;
                raw.ld_pc   = 1'b1;
                raw.pcmux   = PCMUX_INC;
            end
            S_FETCH_RD, S_LDI_RD, S_RD, S_STI_RD: begin
                raw.cs     = 1'b1;
                raw.ld_mdr = 1'b1;
            end
            S_TRAP_RD: begin
                raw.cs      = 1'b1;
                raw.ld_mdr  = 1'b1;
                raw.gate_pc = 1'b1;
                raw.drmux   = DRMUX_R7;
                raw.ld_reg  = 1'b1;
            end
            S_LD_IR: begin
                raw.gate_mdr = 1'b1;
                raw.ld_ir    = 1'b1;
            end
            S_DECODE: raw.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                raw.gate_alu = 1'b1;
                raw.ld_reg   = 1'b1;
                raw.ld_cc    = 1'b1;
                raw.sr1mux   = SR1MUX_IR86;
                raw.drmux    = DRMUX_IR;
                raw.aluk     = (state == S_ADD) ? ALU_ADD :
                               (state == S_AND) ? ALU_AND : ALU_NOT;
            end
            S_BR_TAKE, S_JSR_OFF: begin
                raw.addr1 = ADDR1_PC;
                raw.addr2 = (state == S_BR_TAKE) ? ADDR2_OFF9
                                                 : ADDR2_OFF11;
                raw.pcmux = PCMUX_ADDER;
                raw.ld_pc = 1'b1;
            end
            S_JMP, S_JSRR: begin
                raw.addr1  = ADDR1_SR1;
                raw.sr1mux = SR1MUX_IR86;
                raw.addr2  = ADDR2_ZERO;
                raw.pcmux  = PCMUX_ADDER;
                raw.ld_pc  = 1'b1;
            end
            S_JSR: begin
                raw.gate_pc = 1'b1;
                raw.drmux   = DRMUX_R7;
                raw.ld_reg  = 1'b1;
            end
            S_LD, S_LDI, S_ST, S_STI: begin
                raw.gate_marmux = 1'b1;
                raw.marmux      = MARMUX_ADDER;
                raw.ld_mar      = 1'b1;
                raw.addr1       = ADDR1_PC;
                raw.addr2       = ADDR2_OFF9;
            end
            S_LDR, S_STR: begin
                raw.gate_marmux = 1'b1;
                raw.marmux      = MARMUX_ADDER;
                raw.ld_mar      = 1'b1;
                raw.addr1       = ADDR1_SR1;
                raw.sr1mux      = SR1MUX_IR86;
                raw.addr2       = ADDR2_OFF6;
            end
            S_LDI_MAR, S_STI_MAR: begin
                raw.gate_mdr = 1'b1;
                raw.ld_mar   = 1'b1;
            end
            S_LD_DR: begin
                raw.gate_mdr = 1'b1;
                raw.drmux    = DRMUX_IR;
                raw.ld_reg   = 1'b1;
                raw.ld_cc    = 1'b1;
            end
            S_LEA: begin
                raw.gate_marmux = 1'b1;
                raw.marmux      = MARMUX_ADDER;
                raw.addr1       = ADDR1_PC;
                raw.addr2       = ADDR2_OFF9;
                raw.drmux       = DRMUX_IR;
                raw.ld_reg      = 1'b1;
            end
            S_ST_MDR: begin
                raw.sr1mux   = SR1MUX_IR119;
                raw.aluk     = ALU_PASS;
                raw.gate_alu = 1'b1;
                raw.ld_mdr   = 1'b1;
            end
            S_WR: begin
                raw.cs = 1'b1;
                raw.we = 1'b1;
            end
            S_TRAP: begin
                raw.gate_marmux = 1'b1;
                raw.marmux      = MARMUX_ZEXT;
                raw.ld_mar      = 1'b1;
            end
            S_TRAP_PC: begin
                raw.gate_mdr = 1'b1;
                raw.pcmux    = PCMUX_BUS;
                raw.ld_pc    = 1'b1;
            end
            default: raw = '0;
        endcase
    end

    // Strobes stay quiet for as long as reset is held.
    assign ctl = RESET ? raw : '0;

    lc3_cc_ben u_cc_ben (
        .clk    (CLK),
        .reset  (RESET),
        .bus    (dp.BUS),
        .ir_nzp (dp.IR[11:9]),
        .ld_cc  (ctl.ld_cc),
        .ld_ben (ctl.ld_ben),
        .n      (n),
        .z      (z),
        .p      (p),
        .ben    (ben)
    );

    assign dp.LD_MAR      = ctl.ld_mar;
    assign dp.LD_MDR      = ctl.ld_mdr;
    assign dp.LD_IR       = ctl.ld_ir;
    assign dp.LD_PC       = ctl.ld_pc;
    assign dp.LD_REG      = ctl.ld_reg;
    assign dp.LD_CC       = ctl.ld_cc;
    assign dp.LD_BEN      = ctl.ld_ben;
    assign dp.GateMARMUX  = ctl.gate_marmux;
    assign dp.GateMDR     = ctl.gate_mdr;
    assign dp.GateALU     = ctl.gate_alu;
    assign dp.GatePC      = ctl.gate_pc;
    assign dp.MARMUXsel   = ctl.marmux;
    assign dp.ADDR1MUXsel = ctl.addr1;
    assign dp.ADDR2MUXsel = ctl.addr2;
    assign dp.PCMUXsel    = ctl.pcmux;
    assign dp.DRMUXsel    = ctl.drmux;
    assign dp.SR1MUXsel   = ctl.sr1mux;
    assign dp.ALUK        = ctl.aluk;
    assign dp.CS          = ctl.cs;
    assign dp.WE          = ctl.we;
    assign dp.N           = n;
    assign dp.Z           = z;
    assign dp.P           = p;
    assign dp.BEN         = ben;
endmodule

// File: tb/tb_lc3_control_unit.sv
// Bench for lc3_control_unit: directed scenarios then random
// cycles, all checked against an instruction-level reference model.
module tb_lc3_control_unit;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_pc;
        logic       ld_reg, ld_cc, ld_ben;
        logic       g_marmux, g_mdr, g_alu, g_pc;
        logic       marmux, addr1;
        logic [1:0] addr2, pcmux, drmux, sr1mux, aluk;
        logic       cs, we;
    } cw_t;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    int   st;
    logic mn, mz, mp, mben;

    lc3_ctrl_if dp ();

    lc3_control_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .dp    (dp)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (model state %0d)",
                     tag, got, exp, st);
        end
    endtask

    function automatic cw_t obs();
        cw_t c;
        c.ld_mar   = dp.LD_MAR;
        c.ld_mdr   = dp.LD_MDR;
        c.ld_ir    = dp.LD_IR;
        c.ld_pc    = dp.LD_PC;
        c.ld_reg   = dp.LD_REG;
        c.ld_cc    = dp.LD_CC;
        c.ld_ben   = dp.LD_BEN;
        c.g_marmux = dp.GateMARMUX;
        c.g_mdr    = dp.GateMDR;
        c.g_alu    = dp.GateALU;
        c.g_pc     = dp.GatePC;
        c.marmux   = dp.MARMUXsel;
        c.addr1    = dp.ADDR1MUXsel;
        c.addr2    = dp.ADDR2MUXsel;
        c.pcmux    = dp.PCMUXsel;
        c.drmux    = dp.DRMUXsel;
        c.sr1mux   = dp.SR1MUXsel;
        c.aluk     = dp.ALUK;
        c.cs       = dp.CS;
        c.we       = dp.WE;
        return c;
    endfunction

    // Expected control word per LC-3 microstate.
    function automatic cw_t exp_ctl(int s);
        cw_t c = '0;
        case (s)
            18: begin c.g_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
            33, 24, 25, 29: begin c.cs = 1; c.ld_mdr = 1; end
            28: begin
                c.cs = 1; c.ld_mdr = 1;
                c.g_pc = 1; c.drmux = 1; c.ld_reg = 1;
            end
            35: begin c.g_mdr = 1; c.ld_ir = 1; end
            32: c.ld_ben = 1;
            1, 5, 9: begin
                c.g_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 1;
                c.aluk = (s == 1) ? 2'd0 : (s == 5) ? 2'd1 : 2'd2;
            end
            22: begin c.addr2 = 2; c.pcmux = 2; c.ld_pc = 1; end
            21: begin c.addr2 = 3; c.pcmux = 2; c.ld_pc = 1; end
            12, 20: begin
                c.addr1 = 1; c.sr1mux = 1; c.pcmux = 2; c.ld_pc = 1;
            end
            4: begin c.g_pc = 1; c.drmux = 1; c.ld_reg = 1; end
            2, 10, 3, 11: begin
                c.g_marmux = 1; c.marmux = 1; c.ld_mar = 1; c.addr2 = 2;
            end
            6, 7: begin
                c.g_marmux = 1; c.marmux = 1; c.ld_mar = 1;
                c.addr1 = 1; c.sr1mux = 1; c.addr2 = 1;
            end
            26, 31: begin c.g_mdr = 1; c.ld_mar = 1; end
            27: begin c.g_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
            14: begin
                c.g_marmux = 1; c.marmux = 1; c.addr2 = 2; c.ld_reg = 1;
            end
            23: begin c.aluk = 3; c.g_alu = 1; c.ld_mdr = 1; end
            16: begin c.cs = 1; c.we = 1; end
            15: begin c.g_marmux = 1; c.ld_mar = 1; end
            30: begin c.g_mdr = 1; c.pcmux = 1; c.ld_pc = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic int next_st(int s, logic [15:0] ir,
                                   logic rdy, logic b);
        int op = int'(ir[15:12]);
        if ((s inside {33, 24, 25, 28, 29, 16}) && !rdy) return s;
        case (s)
            18: return 33;
            33: return 35;
            35: return 32;
            32: return (op == 8 || op == 13) ? 18 : op;
            0:  return b ? 22 : 18;
            4:  return ir[11] ? 21 : 20;
            2, 6, 26: return 25;
            25: return 27;
            10: return 24;
            24: return 26;
            3, 7, 31: return 23;
            11: return 29;
            29: return 31;
            23: return 16;
            15: return 28;
            28: return 30;
            default: return 18;
        endcase
    endfunction

    // One clock: drive, check current state outputs, advance model.
    task automatic cyc(input logic [15:0] ir, input logic [15:0] bus,
                       input logic rdy, input logic rst);
        cw_t e;
        int  ns;
        dp.IR    = ir;
        dp.BUS   = bus;
        dp.READY = rdy;
        RESET    = rst;
        #1;
        e = rst ? exp_ctl(st) : '0;
        chk("ctl", 32'(obs()), 32'(e));
        chk("state", 32'(dut.state), 32'(st));
        chk("nzp", 32'({dp.N, dp.Z, dp.P}), 32'({mn, mz, mp}));
        chk("ben", 32'(dp.BEN), 32'(mben));
        @(posedge CLK);
        if (!rst) begin
            st = 18;
            {mn, mz, mp} = 3'b010;
            mben = 1'b0;
        end else begin
            ns = next_st(st, ir, rdy, mben);
            if (st == 32)
                mben = (ir[11] & mn) | (ir[10] & mz) | (ir[9] & mp);
            if (st inside {1, 5, 9, 27}) begin
                mn = bus[15];
                mz = (bus == 16'h0000);
                mp = !mn && !mz;
            end
            st = ns;
        end
        @(negedge CLK);
    endtask

    // Whole instruction from fetch back to 18, random memory waits.
    task automatic instr(input logic [15:0] ir, input logic [15:0] bus);
        int n = 0;
        do begin
            cyc(ir, bus, 1'($urandom_range(0, 2) != 0), 1'b1);
            n++;
        end while (st != 18 && n < 200);
        chk("instr_done", 32'(st), 32'd18);
    endtask

    function automatic logic [15:0] rand_bus();
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'h8000 | 16'($urandom);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        RESET    = 1'b0;
        dp.IR    = '0;
        dp.BUS   = '0;
        dp.READY = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        st = 18;
        {mn, mz, mp} = 3'b010;
        mben = 1'b0;

        cyc(16'h0000, 16'h0000, 1'b0, 1'b0);
        cyc(16'h0000, 16'h0000, 1'b1, 1'b1);
        chk("in_33", 32'(dut.state), 32'd33);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("rst_33", 32'(dut.state), 32'd18);
        chk("rst_strobe", 32'(obs()), 32'd0);
        chk("rst_nzp", 32'({dp.N, dp.Z, dp.P}), 32'd2);

        cyc(16'h1042, 16'h0000, 1'b1, 1'b1);
        cyc(16'h1042, 16'h0000, 1'b0, 1'b1);
        cyc(16'h1042, 16'h0000, 1'b0, 1'b1);
        cyc(16'h1042, 16'h0000, 1'b1, 1'b1);
        chk("to_35", 32'(dut.state), 32'd35);
        cyc(16'h1042, 16'h0000, 1'b1, 1'b1);
        cyc(16'h1042, 16'h0000, 1'b1, 1'b1);
        chk("to_1", 32'(dut.state), 32'd1);
        cyc(16'h1042, 16'h8000, 1'b1, 1'b1);
        chk("nzp_neg", 32'({dp.N, dp.Z, dp.P}), 32'd4);

        instr(16'h1042, 16'h0005);
        chk("nzp_pos", 32'({dp.N, dp.Z, dp.P}), 32'd1);
        instr(16'h0203, 16'h0000);
        chk("ben_set", 32'(dp.BEN), 32'd1);
        instr(16'h0803, 16'h0000);
        chk("ben_clr", 32'(dp.BEN), 32'd0);
        instr(16'hB1FF, 16'h1234);
        instr(16'hF025, 16'h0000);
        instr(16'h8000, 16'h0000);
        instr(16'hD000, 16'h0000);
        instr(16'h4800, 16'h0000);
        instr(16'h4000, 16'h0000);
        instr(16'hA000, 16'hFFFF);
        instr(16'h6000, 16'h0000);

        repeat (300) instr(16'($urandom), rand_bus());

        repeat (3000)
            cyc(16'($urandom), rand_bus(),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 60) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
